// File: rtl/punc_run_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// punc_run_ctrl_pkg
// Shared encodings for the PUnC run/halt/single-step controller:
//   - run_state_e   : HALTED / RUNNING / STEPPING (values seen on run_state)
//   - stop_reason_e : NONE / HOST / BREAK / STEP / HALT_INSTR (stop_reason)
//   - default counter and PC widths
// ---------------------------------------------------------------------------
package punc_run_ctrl_pkg;

  localparam int CNT_W_DEF = 32;
  localparam int PC_W_DEF  = 16;

  typedef enum logic [1:0] {
    ST_HALTED   = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_STEPPING = 2'd2
  } run_state_e;

  typedef enum logic [2:0] {
    RSN_NONE       = 3'd0,
    RSN_HOST       = 3'd1,
    RSN_BREAK      = 3'd2,
    RSN_STEP       = 3'd3,
    RSN_HALT_INSTR = 3'd4
  } stop_reason_e;

endpackage

// File: rtl/punc_run_ctrl.sv
// ---------------------------------------------------------------------------
// punc_run_ctrl
// Run/halt/single-step controller for the PUnC LC3 core. Gates the core
// with a clock enable and only ever pauses it at an instruction boundary
// (fetch state), except for an executed HALT which stops immediately.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cmd_run           pulse: resume free-running (from HALTED only)
//   cmd_step          pulse: execute exactly one instruction (from HALTED)
//   cmd_halt          pulse: stop at the next instruction boundary
//   bp_en, bp_addr    PC breakpoint enable / address
//   pc                current core PC
//   boundary          core is in fetch, about to start instruction at pc
//   halt_instr        core has decoded a HALT instruction
//   cpu_en            core clock enable (combinational)
//   run_state         0 HALTED, 1 RUNNING, 2 STEPPING
//   stop_reason       0 NONE, 1 HOST, 2 BREAK, 3 STEP, 4 HALT_INSTR
//   step_done         one-cycle pulse after a step completes
//   instr_count       instructions started (boundary & cpu_en)
//   cycle_count       cycles with cpu_en=1
// ---------------------------------------------------------------------------
module punc_run_ctrl
  import punc_run_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int PC_W  = PC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_run,
  input  logic             cmd_step,
  input  logic             cmd_halt,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  input  logic             boundary,
  input  logic             halt_instr,
  output logic             cpu_en,
  output logic [1:0]       run_state,
  output logic [2:0]       stop_reason,
  output logic             step_done,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count
);

  run_state_e       state_q, state_d;
  stop_reason_e     reason_q, reason_d;
  logic             halt_pend_q, halt_pend_d;
  logic             skip_bp_q, skip_bp_d;
  logic             step_armed_q, step_armed_d;
  logic             step_done_q, step_done_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;

  logic active_s;
  logic halt_pend_s;
  logic bp_hit_s;
  logic stop_now_s;
  logic cpu_en_s;

  // A halt request arriving on a boundary cycle must stop that same cycle,
  // so the raw command is folded into the pending flag here.
  assign active_s    = (state_q != ST_HALTED);
  assign halt_pend_s = halt_pend_q | cmd_halt;
  assign bp_hit_s    = bp_en & ~skip_bp_q & (pc == bp_addr);
  assign stop_now_s  = active_s &
                       (halt_instr | (boundary & (halt_pend_s | bp_hit_s | step_armed_q)));
  assign cpu_en_s    = active_s & ~stop_now_s;

  // Next-state logic for run state, stop reason and control flags.
  always_comb begin
    state_d      = state_q;
    reason_d     = reason_q;
    halt_pend_d  = halt_pend_q;
    skip_bp_d    = skip_bp_q;
    step_armed_d = step_armed_q;
    step_done_d  = 1'b0;
    case (state_q)
      ST_HALTED: begin
        // cmd_halt outranks run/step; an executed HALT is sticky until reset.
        if (cmd_halt || (reason_q == RSN_HALT_INSTR)) begin
          state_d = ST_HALTED;
        end else if (cmd_step || cmd_run) begin
          state_d      = cmd_step ? ST_STEPPING : ST_RUNNING;
          reason_d     = RSN_NONE;
          halt_pend_d  = 1'b0;
          skip_bp_d    = 1'b1;
          step_armed_d = 1'b0;
        end else begin
          state_d = ST_HALTED;
        end
      end
      ST_RUNNING, ST_STEPPING: begin
        if (stop_now_s) begin
          state_d      = ST_HALTED;
          halt_pend_d  = 1'b0;
          skip_bp_d    = 1'b0;
          step_armed_d = 1'b0;
          if (halt_instr) begin
            reason_d = RSN_HALT_INSTR;
          end else if (halt_pend_s) begin
            reason_d = RSN_HOST;
          end else if (bp_hit_s) begin
            reason_d = RSN_BREAK;
          end else begin
            reason_d    = RSN_STEP;
            step_done_d = 1'b1;
          end
        end else begin
          if (cmd_halt) begin
            halt_pend_d = 1'b1;
          end else begin
            halt_pend_d = halt_pend_q;
          end
          // The breakpoint skip only covers the first boundary after resume.
          if (boundary) begin
            skip_bp_d = 1'b0;
          end else begin
            skip_bp_d = skip_bp_q;
          end
          // First started instruction of a step arms the stop for the next boundary.
          if ((state_q == ST_STEPPING) && boundary) begin
            step_armed_d = 1'b1;
          end else begin
            step_armed_d = step_armed_q;
          end
        end
      end
      default: begin
        state_d      = ST_HALTED;
        reason_d     = RSN_NONE;
        halt_pend_d  = 1'b0;
        skip_bp_d    = 1'b0;
        step_armed_d = 1'b0;
      end
    endcase
  end

  // Free-running counters, wrapping silently.
  always_comb begin
    instr_cnt_d = instr_cnt_q + {{(CNT_W-1){1'b0}}, (boundary & cpu_en_s)};
    cycle_cnt_d = cycle_cnt_q + {{(CNT_W-1){1'b0}}, cpu_en_s};
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_HALTED;
      reason_q     <= RSN_NONE;
      halt_pend_q  <= 1'b0;
      skip_bp_q    <= 1'b0;
      step_armed_q <= 1'b0;
      step_done_q  <= 1'b0;
      instr_cnt_q  <= {CNT_W{1'b0}};
      cycle_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      reason_q     <= reason_d;
      halt_pend_q  <= halt_pend_d;
      skip_bp_q    <= skip_bp_d;
      step_armed_q <= step_armed_d;
      step_done_q  <= step_done_d;
      instr_cnt_q  <= instr_cnt_d;
      cycle_cnt_q  <= cycle_cnt_d;
    end
  end

  assign cpu_en      = cpu_en_s;
  assign run_state   = state_q;
  assign stop_reason = reason_q;
  assign step_done   = step_done_q;
  assign instr_count = instr_cnt_q;
  assign cycle_count = cycle_cnt_q;

endmodule
